// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU: opcode width and the opcode
// encodings understood by alu_comb. Imported by the ALU datapath and by any
// decoder or control unit that issues ALU operations.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0100;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b0101;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b0111;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b1000;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b1001;

endpackage

// File: rtl/alu_comb.sv
// -----------------------------------------------------------------------------
// alu_comb
// Purely combinational ALU operation mux.
//
// Ports:
//   a           in   WIDTH     operand A (rs1)
//   b           in   WIDTH     operand B (rs2 or immediate)
//   operation   in   ALU_OP_W  opcode from alu_pkg
//   next_result out  WIDTH     result of the selected operation
// -----------------------------------------------------------------------------
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [ALU_OP_W-1:0] operation,
    output logic [WIDTH-1:0]    next_result
);

    localparam int SHAMT_W = $clog2(WIDTH);

    // Only the low bits of b form the shift amount; larger amounts wrap.
    logic        [SHAMT_W-1:0] shamt;
    logic signed [WIDTH-1:0]   a_s;
    logic signed [WIDTH-1:0]   b_s;
    logic                      lt_unsigned;
    logic                      lt_signed;

    assign shamt       = b[SHAMT_W-1:0];
    assign a_s         = a;
    assign b_s         = b;
    assign lt_unsigned = (a < b);
    assign lt_signed   = (a_s < b_s);

    always_comb begin
        next_result = '0;
        case (operation)
            ALU_ADD:  next_result = a + b;
            ALU_SUB:  next_result = a - b;
            ALU_AND:  next_result = a & b;
            ALU_OR:   next_result = a | b;
            ALU_SLL:  next_result = a << shamt;
            ALU_SRL:  next_result = a >> shamt;
            ALU_SRA:  next_result = a_s >>> shamt;
            ALU_SLTU: next_result = {{(WIDTH-1){1'b0}}, lt_unsigned};
            ALU_SLT:  next_result = {{(WIDTH-1){1'b0}}, lt_signed};
            ALU_XOR:  next_result = a ^ b;
            // Reserved opcodes produce zero.
            default:  next_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Registered integer ALU for the execute stage. One-cycle latency, one
// operation per cycle, no backpressure.
//
// Ports:
//   clk        in   1         clock, rising edge
//   rst        in   1         asynchronous active-high reset
//   in_valid   in   1         operands and opcode valid this cycle
//   a          in   WIDTH     operand A (rs1)
//   b          in   WIDTH     operand B (rs2 or immediate)
//   operation  in   4         opcode (see alu_pkg)
//   result     out  WIDTH     registered ALU result
//   out_valid  out  1         in_valid delayed by one cycle
//   zero       out  1         registered flag, captured result equals 0
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [ALU_OP_W-1:0] operation,
    output logic [WIDTH-1:0]    result,
    output logic                out_valid,
    output logic                zero
);

    logic [WIDTH-1:0] next_result;

    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_q;
    logic             zero_d;
    logic             zero_q;
    logic             valid_d;
    logic             valid_q;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu_comb (
        .a           (a),
        .b           (b),
        .operation   (operation),
        .next_result (next_result)
    );

    // Result and zero only update on a valid operation; otherwise they hold.
    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        valid_d  = in_valid;
        if (in_valid) begin
            result_d = next_result;
            zero_d   = (next_result == '0);
        end
    end

    // Output register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign result    = result_q;
    assign zero      = zero_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  operation;
    logic [31:0] result;
    logic        out_valid;
    logic        zero;

    int n_tests;
    int n_fail;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_result;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[20];

    alu_core #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .operation (operation),
        .result    (result),
        .out_valid (out_valid),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
        in_valid  = v;
        operation = op;
        a         = va;
        b         = vb;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{"add",        4'b0000, 32'd12345,    32'd123,        32'd12468,     1'b0};
        vecs[1]  = '{"sub",        4'b0001, 32'd12345,    32'd123,        32'd12222,     1'b0};
        vecs[2]  = '{"and",        4'b0010, 32'd12345,    32'd123,        32'd57,        1'b0};
        vecs[3]  = '{"or",         4'b0011, 32'd112345,   32'd123,        32'd112379,    1'b0};
        vecs[4]  = '{"sll27",      4'b0100, 32'd112345,   32'd123,        32'hC800_0000, 1'b0};
        vecs[5]  = '{"srl27",      4'b0101, 32'd112345,   32'd123,        32'd0,         1'b1};
        vecs[6]  = '{"sra27",      4'b0110, 32'd112345,   32'd123,        32'd0,         1'b1};
        vecs[7]  = '{"sltu_false", 4'b0111, 32'd112345,   32'd123,        32'd0,         1'b1};
        vecs[8]  = '{"slt_false",  4'b1000, 32'd112345,   32'd123,        32'd0,         1'b1};
        vecs[9]  = '{"sra_neg",    4'b0110, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0};
        vecs[10] = '{"srl_neg",    4'b0101, 32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0};
        vecs[11] = '{"slt_neg",    4'b1000, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0};
        vecs[12] = '{"sltu_big",   4'b0111, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1};
        vecs[13] = '{"add_wrap",   4'b0000, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1};
        vecs[14] = '{"xor",        4'b1001, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1'b0};
        vecs[15] = '{"rsvd_1111",  4'b1111, 32'd12345,    32'd123,        32'd0,         1'b1};
        vecs[16] = '{"rsvd_1010",  4'b1010, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1};
        vecs[17] = '{"sll_b33",    4'b0100, 32'd12345,    32'd33,         32'd24690,     1'b0};
        vecs[18] = '{"sltu_true",  4'b0111, 32'd5,        32'd7,          32'd1,         1'b0};
        vecs[19] = '{"slt_true",   4'b1000, 32'hFFFF_FFF0, 32'd3,         32'd1,         1'b0};

        // Power-on reset
        rst = 1'b1;
        drive(1'b0, 4'b0000, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", result, 32'd0);
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_zero", {31'd0, zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back table vectors, in_valid held high across them
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            @(posedge clk);
            #1;
            check({vecs[i].name, "_result"}, result, vecs[i].exp_result);
            check({vecs[i].name, "_zero"}, {31'd0, zero}, {31'd0, vecs[i].exp_zero});
            check({vecs[i].name, "_valid"}, {31'd0, out_valid}, 32'd1);
        end

        // Hold: drop in_valid and change inputs to something that would give 0
        @(negedge clk);
        drive(1'b1, 4'b0000, 32'd5, 32'd6);
        @(posedge clk);
        #1;
        check("hold_pre_result", result, 32'd11);
        @(negedge clk);
        drive(1'b0, 4'b0001, 32'd5, 32'd5);
        @(posedge clk);
        #1;
        check("hold_result", result, 32'd11);
        check("hold_zero", {31'd0, zero}, 32'd0);
        check("hold_valid", {31'd0, out_valid}, 32'd0);
        // Input change between edges while valid must not leak through
        drive(1'b1, 4'b0000, 32'd100, 32'd1);
        #2;
        check("midcycle_result", result, 32'd11);

        // Asynchronous reset mid-cycle while out_valid=1
        @(negedge clk);
        drive(1'b1, 4'b0000, 32'd1, 32'd2);
        @(posedge clk);
        #1;
        check("prereset_result", result, 32'd3);
        check("prereset_valid", {31'd0, out_valid}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_result", result, 32'd0);
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_zero", {31'd0, zero}, 32'd0);

        // Operation presented as reset deasserts is captured on the next edge
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 4'b0000, 32'd7, 32'd8);
        @(posedge clk);
        #1;
        check("post_rst_result", result, 32'd15);
        check("post_rst_valid", {31'd0, out_valid}, 32'd1);
        check("post_rst_zero", {31'd0, zero}, 32'd0);
        @(negedge clk);
        drive(1'b0, 4'b0000, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_drop_valid", {31'd0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
